// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - Johnson counter phase decoder with revolution count and fault monitor
// Decodes the 4-bit Johnson code into a one-hot/binary phase and escalates repeated bad samples to a sticky fault.
module johnson_phase_decoder #(
  parameter int REV_W     = 8,
  parameter int ERR_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       jc_q,
  output logic [7:0]       phase,
  output logic [2:0]       phase_idx,
  output logic             valid,
  output logic [REV_W-1:0] rev_count,
  output logic             rev_tick,
  output logic             fault,
  output logic             resync_req
);

  typedef enum logic [1:0] {ST_SYNC, ST_TRACK, ST_FAULT} state_t;

  localparam logic [3:0]       ERR_LIMIT_C = 4'(ERR_LIMIT);
  localparam logic [REV_W-1:0] REV_ONE     = {{(REV_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [7:0]         phase_q, phase_d;
  // phase_idx doubles as the last accepted index; the two always move together.
  logic [2:0]         idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [REV_W-1:0]   rev_q, rev_d;
  logic               tick_q, tick_d;
  logic               fault_q, fault_d;
  logic               resync_q, resync_d;
  logic [3:0]         err_q, err_d;

  logic               legal;
  logic [2:0]         samp_idx;
  logic [2:0]         succ_idx;
  logic [3:0]         err_inc;

  always_comb begin
    legal    = 1'b1;
    samp_idx = 3'd0;
    case (jc_q)
      4'b0000: samp_idx = 3'd0;
      4'b0001: samp_idx = 3'd1;
      4'b0011: samp_idx = 3'd2;
      4'b0111: samp_idx = 3'd3;
      4'b1111: samp_idx = 3'd4;
      4'b1110: samp_idx = 3'd5;
      4'b1100: samp_idx = 3'd6;
      4'b1000: samp_idx = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  assign succ_idx = idx_q + 3'd1;
  assign err_inc  = err_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    rev_d    = rev_q;
    tick_d   = 1'b0;
    fault_d  = fault_q;
    resync_d = 1'b0;
    err_d    = err_q;
    if (en) begin
      case (state_q)
        ST_SYNC: begin
          if (legal) begin
            state_d = ST_TRACK;
            valid_d = 1'b1;
            phase_d = 8'b1 << samp_idx;
            idx_d   = samp_idx;
            err_d   = 4'd0;
          end else begin
            valid_d = 1'b0;
          end
        end
        ST_TRACK: begin
          if (legal && samp_idx == succ_idx) begin
            valid_d = 1'b1;
            phase_d = 8'b1 << samp_idx;
            idx_d   = samp_idx;
            err_d   = 4'd0;
            if (idx_q == 3'd7) begin
              tick_d = 1'b1;
              rev_d  = rev_q + REV_ONE;
            end
          end else if (legal && samp_idx == idx_q) begin
            // stall: counter has not advanced, nothing to do
          end else begin
            valid_d = 1'b0;
            err_d   = err_inc;
            if (err_inc == ERR_LIMIT_C) begin
              state_d  = ST_FAULT;
              fault_d  = 1'b1;
              resync_d = 1'b1;
            end
          end
        end
        ST_FAULT: begin
          valid_d = 1'b0;
          if (jc_q == 4'b0000) begin
            state_d = ST_SYNC;
            fault_d = 1'b0;
            err_d   = 4'd0;
            valid_d = 1'b1;
            phase_d = 8'b0000_0001;
            idx_d   = 3'd0;
          end
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SYNC;
      phase_q  <= 8'd0;
      idx_q    <= 3'd0;
      valid_q  <= 1'b0;
      rev_q    <= '0;
      tick_q   <= 1'b0;
      fault_q  <= 1'b0;
      resync_q <= 1'b0;
      err_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      rev_q    <= rev_d;
      tick_q   <= tick_d;
      fault_q  <= fault_d;
      resync_q <= resync_d;
      err_q    <= err_d;
    end
  end

  assign phase      = phase_q;
  assign phase_idx  = idx_q;
  assign valid      = valid_q;
  assign rev_count  = rev_q;
  assign rev_tick   = tick_q;
  assign fault      = fault_q;
  assign resync_req = resync_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb/tb_johnson_phase_decoder.sv - scoreboard bench for johnson_phase_decoder
// Directed vectors push expected outputs; a negedge monitor pops and compares.
module tb_johnson_phase_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] jc_q = 4'd0;

  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic       valid;
  logic [7:0] rev_count;
  logic       rev_tick;
  logic       fault;
  logic       resync_req;

  logic [7:0] phase2;
  logic [2:0] phase_idx2;
  logic       valid2;
  logic [1:0] rev_count2;
  logic       rev_tick2;
  logic       fault2;
  logic       resync_req2;

  johnson_phase_decoder #(.REV_W(8), .ERR_LIMIT(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .jc_q(jc_q),
    .phase(phase), .phase_idx(phase_idx), .valid(valid),
    .rev_count(rev_count), .rev_tick(rev_tick),
    .fault(fault), .resync_req(resync_req)
  );

  // Narrow revolution counter copy, exercised for wrap at 3->0.
  johnson_phase_decoder #(.REV_W(2), .ERR_LIMIT(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .jc_q(jc_q),
    .phase(phase2), .phase_idx(phase_idx2), .valid(valid2),
    .rev_count(rev_count2), .rev_tick(rev_tick2),
    .fault(fault2), .resync_req(resync_req2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] ph;
    logic [2:0] idx;
    logic       val;
    logic [7:0] rev;
    logic       tick;
    logic       flt;
    logic       rs;
  } exp_t;

  exp_t exp_q[$];
  exp_t mx;
  int   n_vec = 0;
  int   n_err = 0;
  logic [3:0] jc_tab [8];

  task automatic v(input logic r, input logic e, input logic [3:0] jc,
                   input logic [7:0] ph, input logic [2:0] idx, input logic val,
                   input logic [7:0] rev, input logic tick, input logic flt, input logic rs);
    exp_t x;
    rst  = r;
    en   = e;
    jc_q = jc;
    @(posedge clk);
    #1;
    x.ph = ph; x.idx = idx; x.val = val; x.rev = rev;
    x.tick = tick; x.flt = flt; x.rs = rs;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      n_vec++;
      if ({phase, phase_idx, valid, rev_count, rev_tick, fault, resync_req} !==
          {mx.ph, mx.idx, mx.val, mx.rev, mx.tick, mx.flt, mx.rs} ||
          rev_count2 !== mx.rev[1:0] || rev_tick2 !== mx.tick) begin
        n_err++;
        $display("FAIL vec%0d: got ph=%h idx=%0d val=%b rev=%0d tick=%b flt=%b rs=%b rev2=%0d tick2=%b; want ph=%h idx=%0d val=%b rev=%0d tick=%b flt=%b rs=%b rev2=%0d",
                 n_vec, phase, phase_idx, valid, rev_count, rev_tick, fault, resync_req,
                 rev_count2, rev_tick2, mx.ph, mx.idx, mx.val, mx.rev, mx.tick, mx.flt,
                 mx.rs, mx.rev[1:0]);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    jc_tab = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    // reset state
    v(1, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);
    v(1, 0, 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);

    // two clean revolutions; first 0000 only syncs
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++)
        v(0, 1, jc_tab[i], 8'(1 << i), 3'(i), 1, 8'(p), (p == 1 && i == 0), 0, 0);
    v(0, 1, 4'h0, 8'h01, 0, 1, 2, 1, 0, 0);

    // en=0 holds everything, tick drops
    v(0, 0, 4'h5, 8'h01, 0, 1, 2, 0, 0, 0);
    v(0, 1, 4'h1, 8'h02, 1, 1, 2, 0, 0, 0);
    v(0, 1, 4'h3, 8'h04, 2, 1, 2, 0, 0, 0);
    v(0, 1, 4'h7, 8'h08, 3, 1, 2, 0, 0, 0);

    // single glitch recovers without fault
    v(0, 1, 4'h5, 8'h08, 3, 0, 2, 0, 0, 0);
    v(0, 1, 4'hF, 8'h10, 4, 1, 2, 0, 0, 0);
    v(0, 1, 4'hE, 8'h20, 5, 1, 2, 0, 0, 0);
    v(0, 1, 4'hC, 8'h40, 6, 1, 2, 0, 0, 0);
    v(0, 1, 4'h8, 8'h80, 7, 1, 2, 0, 0, 0);
    v(0, 1, 4'h0, 8'h01, 0, 1, 3, 1, 0, 0);
    v(0, 1, 4'h1, 8'h02, 1, 1, 3, 0, 0, 0);
    v(0, 1, 4'h3, 8'h04, 2, 1, 3, 0, 0, 0);

    // two bad samples -> fault with one-cycle resync
    v(0, 1, 4'h5, 8'h04, 2, 0, 3, 0, 0, 0);
    v(0, 1, 4'hA, 8'h04, 2, 0, 3, 0, 1, 1);
    v(0, 1, 4'hA, 8'h04, 2, 0, 3, 0, 1, 0);
    v(0, 1, 4'h3, 8'h04, 2, 0, 3, 0, 1, 0);
    v(0, 1, 4'h0, 8'h01, 0, 1, 3, 0, 0, 0);
    v(0, 1, 4'h1, 8'h02, 1, 1, 3, 0, 0, 0);

    // skip 1->3 is bad, then good step and stall
    v(0, 1, 4'h7, 8'h02, 1, 0, 3, 0, 0, 0);
    v(0, 1, 4'h3, 8'h04, 2, 1, 3, 0, 0, 0);
    v(0, 1, 4'h3, 8'h04, 2, 1, 3, 0, 0, 0);
    // stall between bad samples keeps err count
    v(0, 1, 4'h5, 8'h04, 2, 0, 3, 0, 0, 0);
    v(0, 1, 4'h3, 8'h04, 2, 0, 3, 0, 0, 0);
    v(0, 1, 4'h5, 8'h04, 2, 0, 3, 0, 1, 1);
    v(0, 0, 4'h0, 8'h04, 2, 0, 3, 0, 1, 0);

    // rst beats en while in fault
    v(1, 1, 4'h0, 8'h00, 0, 0, 0, 0, 0, 0);
    v(0, 1, 4'h5, 8'h00, 0, 0, 0, 0, 0, 0);
    v(0, 1, 4'h0, 8'h01, 0, 1, 0, 0, 0, 0);

    // 256 revolutions: 8-bit wraps to 0, 2-bit copy wraps every 4
    for (int r = 1; r <= 256; r++) begin
      for (int i = 1; i < 8; i++)
        v(0, 1, jc_tab[i], 8'(1 << i), 3'(i), 1, 8'(r - 1), 0, 0, 0);
      v(0, 1, 4'h0, 8'h01, 0, 1, 8'(r), 1, 0, 0);
    end

    en = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
